// File: rtl/phase_err_meter.sv
// Phase-error meter: measures the ref_in/fb_in rising-edge offset in clk cycles.
// Define PHASE_ERR_LOCK_DET_EN to build in the lock detector; otherwise lock is tied low.
module phase_err_meter #(
  parameter int W        = 8,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ref_in,
  input  logic                fb_in,
  input  logic                en,
  output logic signed [W-1:0] err,
  output logic                err_valid,
  output logic                up,
  output logic                dn,
  output logic                lock
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } state_t;

  localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};

  logic       ref_s1, ref_s2, ref_h;
  logic       fb_s1, fb_s2, fb_h;
  logic       ref_ev, fb_ev;
  logic [1:0] ref_pipe, fb_pipe;
  logic       ref_go, fb_go;

  state_t       state;
  logic [W-2:0] cnt;
  logic [W-1:0] k;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_s1 <= 1'b0;
      ref_s2 <= 1'b0;
      ref_h  <= 1'b0;
      fb_s1  <= 1'b0;
      fb_s2  <= 1'b0;
      fb_h   <= 1'b0;
    end else begin
      ref_s1 <= ref_in;
      ref_s2 <= ref_s1;
      ref_h  <= ref_s2;
      fb_s1  <= fb_in;
      fb_s2  <= fb_s1;
      fb_h   <= fb_s2;
    end
  end

  assign ref_ev = ref_s2 & ~ref_h;
  assign fb_ev  = fb_s2 & ~fb_h;

  // Two event stages put err_valid four edges after the first input sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_pipe <= '0;
      fb_pipe  <= '0;
    end else begin
      ref_pipe <= {ref_pipe[0], ref_ev};
      fb_pipe  <= {fb_pipe[0], fb_ev};
    end
  end

  assign ref_go = ref_pipe[1];
  assign fb_go  = fb_pipe[1];

  // cnt holds k-1 while measuring, so k is the offset if the close lands this cycle.
  assign k = {1'b0, cnt} + {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      err       <= '0;
      err_valid <= 1'b0;
      up        <= 1'b0;
      dn        <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
        up    <= 1'b0;
        dn    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (ref_go && fb_go) begin
              err       <= '0;
              err_valid <= 1'b1;
            end else if (ref_go) begin
              state <= REF_LEAD;
              cnt   <= '0;
              up    <= 1'b1;
            end else if (fb_go) begin
              state <= FB_LEAD;
              cnt   <= '0;
              dn    <= 1'b1;
            end
          end
          REF_LEAD: begin
            if (fb_go) begin
              err       <= k;
              err_valid <= 1'b1;
              cnt       <= '0;
              // A simultaneous ref edge reopens the measurement instead of slipping.
              if (!ref_go) begin
                state <= IDLE;
                up    <= 1'b0;
              end
            end else if (ref_go) begin
              err       <= MAX;
              err_valid <= 1'b1;
              cnt       <= '0;
            end else if (k == MAX) begin
              err       <= MAX;
              err_valid <= 1'b1;
              cnt       <= '0;
              state     <= IDLE;
              up        <= 1'b0;
            end else begin
              cnt <= k[W-2:0];
            end
          end
          FB_LEAD: begin
            if (ref_go) begin
              err       <= -k;
              err_valid <= 1'b1;
              cnt       <= '0;
              if (!fb_go) begin
                state <= IDLE;
                dn    <= 1'b0;
              end
            end else if (fb_go) begin
              err       <= -MAX;
              err_valid <= 1'b1;
              cnt       <= '0;
            end else if (k == MAX) begin
              err       <= -MAX;
              err_valid <= 1'b1;
              cnt       <= '0;
              state     <= IDLE;
              dn        <= 1'b0;
            end else begin
              cnt <= k[W-2:0];
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            up    <= 1'b0;
            dn    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PHASE_ERR_LOCK_DET_EN
  localparam int unsigned   RUN_W   = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);
  localparam logic [W-1:0]  TOL     = W'(LOCK_TOL);

  logic [RUN_W-1:0] lock_run;
  logic [W-1:0]     err_abs;

  assign err_abs = err[W-1] ? $unsigned(-err) : $unsigned(err);

  // Timeouts and slips report |err| = MAX, so they fall out of tolerance naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_run <= '0;
    end else if (!en) begin
      lock_run <= '0;
    end else if (err_valid) begin
      if (err_abs <= TOL) begin
        if (lock_run != RUN_MAX) lock_run <= lock_run + RUN_W'(1);
      end else begin
        lock_run <= '0;
      end
    end
  end

  assign lock = (lock_run == RUN_MAX);
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_phase_err_meter.sv
// Directed bench for phase_err_meter; lock checks are built when PHASE_ERR_LOCK_DET_EN is defined.
`timescale 1ns/1ps
module tb_phase_err_meter;
  localparam int W = 8;

  logic                clk    = 1'b0;
  logic                rst    = 1'b0;
  logic                ref_in = 1'b0;
  logic                fb_in  = 1'b0;
  logic                en     = 1'b1;
  logic signed [W-1:0] err;
  logic                err_valid, up, dn, lock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ev_total = 0, up_total = 0, dn_total = 0, both_total = 0;
  logic signed [W-1:0] err_q[$];
  int                  vcyc_q[$];
  logic                lock_at_q[$];
  logic                lock_after_q[$];
  logic                pend = 1'b0;
  logic                lock_seen = 1'b0;

  phase_err_meter #(.W(W), .LOCK_TOL(2), .LOCK_CNT(16)) dut (
    .clk(clk), .rst(rst), .ref_in(ref_in), .fb_in(fb_in), .en(en),
    .err(err), .err_valid(err_valid), .up(up), .dn(dn), .lock(lock)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pend) lock_after_q.push_back(lock);
    pend <= err_valid;
    if (err_valid) begin
      ev_total <= ev_total + 1;
      err_q.push_back(err);
      vcyc_q.push_back(cyc);
      lock_at_q.push_back(lock);
    end
    if (up) up_total <= up_total + 1;
    if (dn) dn_total <= dn_total + 1;
    if (up && dn) both_total <= both_total + 1;
    if (lock) lock_seen <= 1'b1;
  end

  function automatic logic signed [W-1:0] err_at(input int i);
    if (i < err_q.size()) return err_q[i];
    return 'x;
  endfunction

  function automatic int vcyc_at(input int i);
    if (i < vcyc_q.size()) return vcyc_q[i];
    return -1;
  endfunction

  function automatic logic lock_at(input int i);
    if (i < lock_at_q.size()) return lock_at_q[i];
    return 1'bx;
  endfunction

  function automatic logic lock_after(input int i);
    if (i < lock_after_q.size()) return lock_after_q[i];
    return 1'bx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(3);
    checks++; if (err !== 8'sd0) begin errors++; $display("FAIL rst_err got %0d want 0", err); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", err_valid); end
    checks++; if ({up, dn} !== 2'b00) begin errors++; $display("FAIL rst_updn got %b want 00", {up, dn}); end
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL rst_lock got %b want 0", lock); end
    rst = 1'b1;
    tick(4);
    checks++; if (ev_total !== 0) begin errors++; $display("FAIL rst_noev got %0d want 0", ev_total); end
  endtask

  task automatic test_ref_lead;
    int base, ub, db, c1;
    base = ev_total; ub = up_total; db = dn_total;
    ref_in = 1'b1;
    tick(5);
    c1 = cyc;
    fb_in = 1'b1;
    tick(10);
    ref_in = 1'b0; fb_in = 1'b0;
    tick(4);
    checks++; if (ev_total - base !== 1) begin errors++; $display("FAIL ref_lead_count got %0d want 1", ev_total - base); end
    checks++; if (err_at(base) !== 8'sd5) begin errors++; $display("FAIL ref_lead_err got %0d want 5", err_at(base)); end
    checks++; if (up_total - ub !== 5) begin errors++; $display("FAIL ref_lead_up got %0d want 5", up_total - ub); end
    checks++; if (dn_total - db !== 0) begin errors++; $display("FAIL ref_lead_dn got %0d want 0", dn_total - db); end
    checks++; if (vcyc_at(base) - c1 !== 5) begin errors++; $display("FAIL latency got %0d want 5", vcyc_at(base) - c1); end
  endtask

  task automatic test_fb_lead;
    int base, ub, db;
    base = ev_total; ub = up_total; db = dn_total;
    fb_in = 1'b1;
    tick(12);
    ref_in = 1'b1;
    tick(10);
    ref_in = 1'b0; fb_in = 1'b0;
    tick(4);
    checks++; if (ev_total - base !== 1) begin errors++; $display("FAIL fb_lead_count got %0d want 1", ev_total - base); end
    checks++; if (err_at(base) !== -8'sd12) begin errors++; $display("FAIL fb_lead_err got %0d want -12", err_at(base)); end
    checks++; if (dn_total - db !== 12) begin errors++; $display("FAIL fb_lead_dn got %0d want 12", dn_total - db); end
    checks++; if (up_total - ub !== 0) begin errors++; $display("FAIL fb_lead_up got %0d want 0", up_total - ub); end
    tick(20);
    checks++; if (err !== -8'sd12) begin errors++; $display("FAIL err_hold got %0d want -12", err); end
  endtask

  task automatic test_same_edge;
    int base, ub, db;
    base = ev_total; ub = up_total; db = dn_total;
    ref_in = 1'b1; fb_in = 1'b1;
    tick(10);
    ref_in = 1'b0; fb_in = 1'b0;
    tick(4);
    checks++; if (ev_total - base !== 1) begin errors++; $display("FAIL same_count got %0d want 1", ev_total - base); end
    checks++; if (err_at(base) !== 8'sd0) begin errors++; $display("FAIL same_err got %0d want 0", err_at(base)); end
    checks++; if (up_total - ub + dn_total - db !== 0) begin errors++; $display("FAIL same_updn got %0d want 0", up_total - ub + dn_total - db); end
  endtask

  task automatic test_timeout;
    int base, ub;
    base = ev_total; ub = up_total;
    ref_in = 1'b1;
    tick(200);
    checks++; if (ev_total - base !== 1) begin errors++; $display("FAIL timeout_count got %0d want 1", ev_total - base); end
    checks++; if (err_at(base) !== 8'sd127) begin errors++; $display("FAIL timeout_err got %0d want 127", err_at(base)); end
    checks++; if (up_total - ub !== 127) begin errors++; $display("FAIL timeout_up got %0d want 127", up_total - ub); end
    checks++; if ({up, dn} !== 2'b00) begin errors++; $display("FAIL timeout_idle got %b want 00", {up, dn}); end
    ref_in = 1'b0;
    tick(4);
  endtask

  task automatic test_slip;
    int base, ub;
    base = ev_total; ub = up_total;
    ref_in = 1'b1; tick(2); ref_in = 1'b0; tick(4);
    ref_in = 1'b1; tick(2); ref_in = 1'b0; tick(2);
    fb_in = 1'b1; tick(2); fb_in = 1'b0;
    tick(10);
    checks++; if (ev_total - base !== 2) begin errors++; $display("FAIL slip_count got %0d want 2", ev_total - base); end
    checks++; if (err_at(base) !== 8'sd127) begin errors++; $display("FAIL slip_err got %0d want 127", err_at(base)); end
    checks++; if (err_at(base + 1) !== 8'sd4) begin errors++; $display("FAIL slip_close got %0d want 4", err_at(base + 1)); end
    checks++; if (up_total - ub !== 10) begin errors++; $display("FAIL slip_up got %0d want 10", up_total - ub); end
  endtask

  task automatic test_slip_and_close;
    int base, ub, db;
    base = ev_total; ub = up_total; db = dn_total;
    ref_in = 1'b1; tick(2); ref_in = 1'b0; tick(4);
    ref_in = 1'b1; fb_in = 1'b1; tick(2);
    ref_in = 1'b0; fb_in = 1'b0; tick(2);
    fb_in = 1'b1; tick(2); fb_in = 1'b0;
    tick(10);
    checks++; if (ev_total - base !== 2) begin errors++; $display("FAIL slipclose_count got %0d want 2", ev_total - base); end
    checks++; if (err_at(base) !== 8'sd6) begin errors++; $display("FAIL slipclose_first got %0d want 6", err_at(base)); end
    checks++; if (err_at(base + 1) !== 8'sd4) begin errors++; $display("FAIL slipclose_second got %0d want 4", err_at(base + 1)); end
    checks++; if (up_total - ub !== 10) begin errors++; $display("FAIL slipclose_up got %0d want 10", up_total - ub); end
    checks++; if (dn_total - db !== 0) begin errors++; $display("FAIL slipclose_dn got %0d want 0", dn_total - db); end
  endtask

  task automatic test_enable;
    int base, db;
    base = ev_total; db = dn_total;
    ref_in = 1'b1;
    tick(8);
    checks++; if (up !== 1'b1) begin errors++; $display("FAIL en_pre_up got %b want 1", up); end
    en = 1'b0;
    tick(1);
    checks++; if (up !== 1'b0) begin errors++; $display("FAIL en_low_up got %b want 0", up); end
    fb_in = 1'b1;
    tick(8);
    en = 1'b1;
    tick(4);
    ref_in = 1'b0; fb_in = 1'b0;
    tick(6);
    checks++; if (ev_total - base !== 0) begin errors++; $display("FAIL en_noev got %0d want 0", ev_total - base); end
    checks++; if (err !== 8'sd4) begin errors++; $display("FAIL en_err_hold got %0d want 4", err); end
    checks++; if (dn_total - db !== 0) begin errors++; $display("FAIL en_dn got %0d want 0", dn_total - db); end
  endtask

  task automatic test_reset_mid;
    int base;
    ref_in = 1'b1;
    tick(8);
    checks++; if (up !== 1'b1) begin errors++; $display("FAIL rstmid_pre_up got %b want 1", up); end
    rst = 1'b0;
    #1;
    checks++; if ({err_valid, up, dn, lock} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags got %b want 0000", {err_valid, up, dn, lock}); end
    checks++; if (err !== 8'sd0) begin errors++; $display("FAIL rstmid_err got %0d want 0", err); end
    ref_in = 1'b0;
    base = ev_total;
    tick(3);
    rst = 1'b1;
    tick(20);
    checks++; if (ev_total - base !== 0) begin errors++; $display("FAIL rstmid_noev got %0d want 0", ev_total - base); end
    ref_in = 1'b1; tick(3);
    fb_in = 1'b1; tick(10);
    ref_in = 1'b0; fb_in = 1'b0; tick(4);
    checks++; if (ev_total - base !== 1) begin errors++; $display("FAIL rstmid_after_count got %0d want 1", ev_total - base); end
    checks++; if (err_at(base) !== 8'sd3) begin errors++; $display("FAIL rstmid_after_err got %0d want 3", err_at(base)); end
  endtask

`ifdef PHASE_ERR_LOCK_DET_EN
  task automatic test_lock;
    int idx;
    for (int i = 0; i < 16; i++) begin
      ref_in = 1'b1; tick(1);
      fb_in = 1'b1; tick(6);
      ref_in = 1'b0; fb_in = 1'b0; tick(4);
      if (i == 14) begin
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL lock_15 got %b want 0", lock); end
      end
    end
    idx = ev_total - 1;
    checks++; if (err_at(idx) !== 8'sd1) begin errors++; $display("FAIL lock_err got %0d want 1", err_at(idx)); end
    checks++; if (lock_at(idx) !== 1'b0) begin errors++; $display("FAIL lock_at16 got %b want 0", lock_at(idx)); end
    checks++; if (lock_after(idx) !== 1'b1) begin errors++; $display("FAIL lock_rise got %b want 1", lock_after(idx)); end
    ref_in = 1'b1; tick(3);
    fb_in = 1'b1; tick(8);
    ref_in = 1'b0; fb_in = 1'b0; tick(4);
    idx = ev_total - 1;
    checks++; if (err_at(idx) !== 8'sd3) begin errors++; $display("FAIL unlock_err got %0d want 3", err_at(idx)); end
    checks++; if (lock_at(idx) !== 1'b1) begin errors++; $display("FAIL unlock_at got %b want 1", lock_at(idx)); end
    checks++; if (lock_after(idx) !== 1'b0) begin errors++; $display("FAIL unlock_fall got %b want 0", lock_after(idx)); end
  endtask
`else
  task automatic test_lock;
    checks++; if (lock_seen !== 1'b0) begin errors++; $display("FAIL lock_tied got %b want 0", lock_seen); end
  endtask
`endif

  task automatic test_exclusive;
    checks++; if (both_total !== 0) begin errors++; $display("FAIL updn_excl got %0d want 0", both_total); end
  endtask

  initial begin
    test_reset;
    test_ref_lead;
    test_fb_lead;
    test_same_edge;
    test_timeout;
    test_slip;
    test_slip_and_close;
    test_enable;
    test_reset_mid;
    test_lock;
    test_exclusive;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_err_meter.md
PHASE_ERR_METER -- requirements
Module: phase_err_meter

Interface
REQ-001 Parameter W, default 8: width of signed phase-error output, two's complement.
REQ-002 Parameter LOCK_TOL, default 2: max |err| (clk cycles) counted as in-tolerance.
REQ-003 Parameter LOCK_CNT, default 16: consecutive in-tolerance measurements required for lock.
REQ-004 clk  input  1  sampling clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 ref_in  input  1  reference clock, asynchronous to clk.
REQ-007 fb_in  input  1  feedback clock from the N divider, asynchronous to clk.
REQ-008 en  input  1  measurement enable, synchronous to clk.
REQ-009 err  output  W  signed phase error in clk cycles; positive = ref leads fb.
REQ-010 err_valid  output  1  one-cycle pulse; err updated in the same cycle.
REQ-011 up  output  1  high while ref edge seen and fb edge pending.
REQ-012 dn  output  1  high while fb edge seen and ref edge pending.
REQ-013 lock  output  1  lock indicator (see Configuration).

Function
REQ-014 ref_in and fb_in SHALL each pass through an identical 2-flop synchronizer plus one history flop; rising-edge event = stage2 high and history low.
REQ-015 FSM states SHALL be IDLE, REF_LEAD, FB_LEAD; up = (state==REF_LEAD), dn = (state==FB_LEAD), both registered from state.
REQ-016 IDLE: ref event only -> REF_LEAD, counter = 0; fb event only -> FB_LEAD, counter = 0; both in same cycle -> stay IDLE, err = 0, err_valid = 1.
REQ-017 REF_LEAD/FB_LEAD: counter SHALL increment by 1 each cycle without a closing event, so a closing event k cycles after the opening event yields |err| = k.
REQ-018 REF_LEAD + fb event -> err = +k, err_valid = 1, IDLE; FB_LEAD + ref event -> err = -k, err_valid = 1, IDLE.
REQ-019 Magnitude SHALL saturate at MAX = 2^(W-1)-1; on reaching MAX without closing event, err = +/-MAX, err_valid = 1, IDLE (timeout).
REQ-020 Cycle slip: REF_LEAD + ref event (no fb) -> err = +MAX, err_valid = 1, remain REF_LEAD, counter = 0; symmetric for FB_LEAD (-MAX).
REQ-021 Cycle slip and closing event in same cycle: closing event wins, err = +/-k, then REF_LEAD/FB_LEAD restarts with counter = 0 for the new opening edge.
REQ-022 err SHALL hold its value between err_valid pulses.
REQ-023 en low SHALL force IDLE, clear counter, suppress err_valid, clear lock qualification count; synchronizers keep running; err holds.
REQ-024 Latency: err_valid SHALL assert 4 clk edges after the first clk edge sampling the closing input high.

Reset
REQ-025 rst low SHALL asynchronously clear synchronizers, history flops, counter, state (IDLE), err = 0, err_valid = 0, up = 0, dn = 0, lock = 0.
REQ-026 Reset mid-measurement SHALL discard the pending measurement; no err_valid on release.
REQ-027 After rst release, first edge event is recognised no earlier than the 3rd clk edge.

Configuration
REQ-028 Macro PHASE_ERR_LOCK_DET_EN defined: lock detector compiled in; lock_run counter increments on each err_valid with |err| <= LOCK_TOL, saturating at LOCK_CNT, clears on err_valid with |err| > LOCK_TOL; lock = (lock_run == LOCK_CNT).
REQ-029 Lock deassertion SHALL occur in the cycle after the out-of-tolerance err_valid; timeouts and slips count as out-of-tolerance.
REQ-030 Macro undefined: no lock logic synthesised; lock tied 0.

Verification
REQ-031 ref rises, fb rises 5 clk later (en=1, W=8) -> single err_valid, err = +5, up high for 5 cycles, dn low.
REQ-032 fb rises, ref rises 12 clk later -> err = -12, dn high 12 cycles.
REQ-033 ref and fb rise on same clk edge -> err = 0, err_valid one cycle, up = dn = 0 throughout.
REQ-034 ref rises, no fb for 200 cycles -> err = +127 at counter 127, err_valid once, return IDLE; ref twice before fb -> err = +127 slip pulse, then err = k from second ref edge.
REQ-035 With PHASE_ERR_LOCK_DET_EN: 16 measurements of err = +1 -> lock rises after the 16th err_valid; one err = +3 -> lock falls next cycle.
REQ-036 rst low 3 cycles after ref edge (before fb) -> all outputs 0 immediately; after release, no err_valid until a new edge pair.
